fpadd_avmm_initiator: RTL and testbench

Avalon-MM host that drives the memory-mapped FP-add accelerator from the other side of its slave port. It accepts an operand pair on a valid/ready command interface and writes operand A (offset 0), operand B (offset 1) and a GO word (offset 3). It then reads the result (offset 4) and returns it on a valid/ready response interface. It sits between a Nios II-side or DMA-side command source and the accelerator's avalon_slave_0.

---
 rtl/fpadd_avmm_pkg.sv | 25 ++
 rtl/fpadd_avmm_initiator.sv | 193 +++++++++++++++++++
 tb/tb_fpadd_avmm_initiator.sv | 322 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpadd_avmm_pkg.sv
// Shared definitions for the FP-add accelerator Avalon-MM initiator.
// Holds the FSM state encoding plus the default register map of the
// accelerator's slave port (operand A/B, GO trigger, result).
package fpadd_avmm_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_WR_A    = 3'd1,
    ST_WR_B    = 3'd2,
    ST_WR_GO   = 3'd3,
    ST_RD_REQ  = 3'd4,
    ST_RD_WAIT = 3'd5,
    ST_RESP    = 3'd6
  } state_e;

  // Default word offsets inside the accelerator's register map
  localparam int unsigned DEF_OFF_A   = 0;
  localparam int unsigned DEF_OFF_B   = 1;
  localparam int unsigned DEF_OFF_GO  = 3;
  localparam int unsigned DEF_OFF_RES = 4;

  // Value written to the GO register to start an addition
  localparam logic [31:0] DEF_GO_WORD = 32'h0000_0001;

endpackage

// File: rtl/fpadd_avmm_initiator.sv
// Avalon-MM host for the memory-mapped FP-add accelerator.
// A command (operand pair) is taken on a valid/ready interface, written to
// the accelerator as A, B and GO, then the result is read back and offered
// on a valid/ready response interface (with a timeout flag if the read
// data never arrives).
//
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   cmd_valid/ready    command handshake, cmd_a/cmd_b operands
//   rsp_valid/ready    response handshake, rsp_result sum,
//                      rsp_timeout marks a result that timed out
//   avm_*              Avalon-MM host port (all outputs registered)
//   busy               FSM is not idle
//   ops_done           wrapping count of completed responses
module fpadd_avmm_initiator
  import fpadd_avmm_pkg::*;
#(
  parameter int unsigned    DATA_W  = 32,
  parameter int unsigned    ADDR_W  = 3,
  parameter int unsigned    OFF_A   = DEF_OFF_A,
  parameter int unsigned    OFF_B   = DEF_OFF_B,
  parameter int unsigned    OFF_GO  = DEF_OFF_GO,
  parameter int unsigned    OFF_RES = DEF_OFF_RES,
  parameter logic [DATA_W-1:0] GO_WORD = DATA_W'(DEF_GO_WORD),
  parameter int unsigned    TIMEOUT = 1024,
  parameter int unsigned    CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_result,
  output logic              rsp_timeout,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [DATA_W-1:0] avm_writedata,
  input  logic [DATA_W-1:0] avm_readdata,
  input  logic              avm_readdatavalid,
  input  logic              avm_waitrequest,
  output logic              busy,
  output logic [CNT_W-1:0]  ops_done
);

  localparam int unsigned TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   op_a_q, op_a_d;
  logic [DATA_W-1:0]   op_b_q, op_b_d;
  logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
  logic [DATA_W-1:0]   rsp_result_q, rsp_result_d;
  logic                rsp_timeout_q, rsp_timeout_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic [ADDR_W-1:0]   avm_address_q, avm_address_d;
  logic                avm_read_q, avm_read_d;
  logic                avm_write_q, avm_write_d;
  logic [DATA_W-1:0]   avm_writedata_q, avm_writedata_d;
  logic [CNT_W-1:0]    ops_done_q, ops_done_d;
  logic                xfer_accepted;

  // A pending read or write is taken by the slave in any cycle it does not stall
  assign xfer_accepted = (avm_write_q || avm_read_q) && !avm_waitrequest;

  always_comb begin
    state_d         = state_q;
    op_a_d          = op_a_q;
    op_b_d          = op_b_q;
    tmo_cnt_d       = tmo_cnt_q;
    rsp_result_d    = rsp_result_q;
    rsp_timeout_d   = rsp_timeout_q;
    ops_done_d      = ops_done_q;

    case (state_q)
      ST_IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          op_a_d  = cmd_a;
          op_b_d  = cmd_b;
          state_d = ST_WR_A;
        end
      end
      ST_WR_A:  if (xfer_accepted) state_d = ST_WR_B;
      ST_WR_B:  if (xfer_accepted) state_d = ST_WR_GO;
      ST_WR_GO: if (xfer_accepted) state_d = ST_RD_REQ;
      ST_RD_REQ: begin
        if (xfer_accepted) begin
          state_d   = ST_RD_WAIT;
          tmo_cnt_d = '0;
        end
      end
      ST_RD_WAIT: begin
        // Being in RD_WAIT already excludes a strobe in the acceptance cycle
        if (avm_readdatavalid) begin
          rsp_result_d  = avm_readdata;
          rsp_timeout_d = 1'b0;
          state_d       = ST_RESP;
        end else if (tmo_cnt_q == TMO_W'(TIMEOUT - 1)) begin
          rsp_result_d  = '0;
          rsp_timeout_d = 1'b1;
          state_d       = ST_RESP;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          ops_done_d = ops_done_q + 1'b1;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Interface outputs are decoded from the next state so that they are
    // registered yet line up with the state they belong to.
    cmd_ready_d     = (state_d == ST_IDLE);
    rsp_valid_d     = (state_d == ST_RESP);
    avm_write_d     = 1'b0;
    avm_read_d      = 1'b0;
    avm_address_d   = '0;
    avm_writedata_d = '0;
    case (state_d)
      ST_WR_A: begin
        avm_write_d     = 1'b1;
        avm_address_d   = ADDR_W'(OFF_A);
        avm_writedata_d = op_a_d;
      end
      ST_WR_B: begin
        avm_write_d     = 1'b1;
        avm_address_d   = ADDR_W'(OFF_B);
        avm_writedata_d = op_b_d;
      end
      ST_WR_GO: begin
        avm_write_d     = 1'b1;
        avm_address_d   = ADDR_W'(OFF_GO);
        avm_writedata_d = GO_WORD;
      end
      ST_RD_REQ: begin
        avm_read_d      = 1'b1;
        avm_address_d   = ADDR_W'(OFF_RES);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      op_a_q          <= '0;
      op_b_q          <= '0;
      tmo_cnt_q       <= '0;
      rsp_result_q    <= '0;
      rsp_timeout_q   <= 1'b0;
      rsp_valid_q     <= 1'b0;
      cmd_ready_q     <= 1'b0;
      avm_address_q   <= '0;
      avm_read_q      <= 1'b0;
      avm_write_q     <= 1'b0;
      avm_writedata_q <= '0;
      ops_done_q      <= '0;
    end else begin
      state_q         <= state_d;
      op_a_q          <= op_a_d;
      op_b_q          <= op_b_d;
      tmo_cnt_q       <= tmo_cnt_d;
      rsp_result_q    <= rsp_result_d;
      rsp_timeout_q   <= rsp_timeout_d;
      rsp_valid_q     <= rsp_valid_d;
      cmd_ready_q     <= cmd_ready_d;
      avm_address_q   <= avm_address_d;
      avm_read_q      <= avm_read_d;
      avm_write_q     <= avm_write_d;
      avm_writedata_q <= avm_writedata_d;
      ops_done_q      <= ops_done_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_result    = rsp_result_q;
  assign rsp_timeout   = rsp_timeout_q;
  assign avm_address   = avm_address_q;
  assign avm_read      = avm_read_q;
  assign avm_write     = avm_write_q;
  assign avm_writedata = avm_writedata_q;
  assign busy          = (state_q != ST_IDLE);
  assign ops_done      = ops_done_q;

endmodule

// File: tb/tb_fpadd_avmm_initiator.sv
// Directed bench for fpadd_avmm_initiator. Two instances are used: one
// built with TIMEOUT = 16 for the timeout case and most scenarios, one with
// the default TIMEOUT for the 20-cycle read-latency case. use_long selects
// which instance the slave model and the checks talk to.
module tb_fpadd_avmm_initiator;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        rsp_ready = 1'b0;
  logic [31:0] cmd_a = '0;
  logic [31:0] cmd_b = '0;
  logic [31:0] avm_readdata = '0;
  logic        avm_readdatavalid = 1'b0;
  logic        avm_waitrequest = 1'b0;
  logic        use_long = 1'b0;

  always #5 clk = ~clk;

  logic        s_cmd_valid, l_cmd_valid;
  logic        s_cmd_ready, s_rsp_valid, s_rsp_timeout, s_avm_read, s_avm_write, s_busy;
  logic        l_cmd_ready, l_rsp_valid, l_rsp_timeout, l_avm_read, l_avm_write, l_busy;
  logic [31:0] s_rsp_result, s_avm_writedata, l_rsp_result, l_avm_writedata;
  logic [2:0]  s_avm_address, l_avm_address;
  logic [15:0] s_ops_done, l_ops_done;

  logic        cmd_ready, rsp_valid, rsp_timeout, avm_read, avm_write, busy;
  logic [31:0] rsp_result, avm_writedata;
  logic [2:0]  avm_address;
  logic [15:0] ops_done;

  assign s_cmd_valid   = cmd_valid & ~use_long;
  assign l_cmd_valid   = cmd_valid & use_long;
  assign cmd_ready     = use_long ? l_cmd_ready     : s_cmd_ready;
  assign rsp_valid     = use_long ? l_rsp_valid     : s_rsp_valid;
  assign rsp_timeout   = use_long ? l_rsp_timeout   : s_rsp_timeout;
  assign rsp_result    = use_long ? l_rsp_result    : s_rsp_result;
  assign avm_read      = use_long ? l_avm_read      : s_avm_read;
  assign avm_write     = use_long ? l_avm_write     : s_avm_write;
  assign avm_address   = use_long ? l_avm_address   : s_avm_address;
  assign avm_writedata = use_long ? l_avm_writedata : s_avm_writedata;
  assign busy          = use_long ? l_busy          : s_busy;
  assign ops_done      = use_long ? l_ops_done      : s_ops_done;

  fpadd_avmm_initiator #(.TIMEOUT(16)) u_dut_short (
    .clk(clk), .reset(reset),
    .cmd_valid(s_cmd_valid), .cmd_ready(s_cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(s_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(s_rsp_result),
    .rsp_timeout(s_rsp_timeout),
    .avm_address(s_avm_address), .avm_read(s_avm_read), .avm_write(s_avm_write),
    .avm_writedata(s_avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .busy(s_busy), .ops_done(s_ops_done)
  );

  fpadd_avmm_initiator u_dut_long (
    .clk(clk), .reset(reset),
    .cmd_valid(l_cmd_valid), .cmd_ready(l_cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .rsp_valid(l_rsp_valid), .rsp_ready(rsp_ready), .rsp_result(l_rsp_result),
    .rsp_timeout(l_rsp_timeout),
    .avm_address(l_avm_address), .avm_read(l_avm_read), .avm_write(l_avm_write),
    .avm_writedata(l_avm_writedata), .avm_readdata(avm_readdata),
    .avm_readdatavalid(avm_readdatavalid), .avm_waitrequest(avm_waitrequest),
    .busy(l_busy), .ops_done(l_ops_done)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboards: expected bus writes {addr, data} and responses {timeout, result}
  logic [34:0] wr_q[$];
  logic [32:0] rsp_q[$];

  // Cycle bookkeeping: cyc counts rising edges, hs_cyc is the edge of the
  // last command handshake, rd_acc_cyc the edge a read was accepted on.
  int cyc = 0;
  int hs_cyc = 0;
  int rd_acc_cyc = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cmd_valid && cmd_ready) hs_cyc <= cyc + 1;
  end

  // Avalon slave model, driven on the falling edge
  int          cfg_stall = 0;
  int          cfg_lat = 1;
  logic        cfg_spur = 1'b0;
  logic        cfg_norsp = 1'b0;
  logic [31:0] cfg_rdata = '0;
  int          stall_cnt = 0;
  int          rd_cnt = 0;
  logic [37:0] hold_bus = '0;

  always @(negedge clk) begin
    logic [34:0] exp_wr;
    avm_readdatavalid <= 1'b0;
    avm_readdata      <= 32'hDEAD_BEEF;
    if (reset) begin
      stall_cnt       <= 0;
      rd_cnt          <= 0;
      avm_waitrequest <= 1'b0;
    end else begin
      if (rd_cnt != 0) begin
        if (rd_cnt == 1) begin
          avm_readdatavalid <= 1'b1;
          avm_readdata      <= cfg_rdata;
        end
        rd_cnt <= rd_cnt - 1;
      end
      if (avm_write || avm_read) begin
        if (stall_cnt != 0)
          check("bus_stable_in_stall", {26'd0, avm_address, avm_write, avm_read, avm_writedata},
                {26'd0, hold_bus});
        else
          hold_bus <= {avm_address, avm_write, avm_read, avm_writedata};
        if (stall_cnt < cfg_stall) begin
          avm_waitrequest <= 1'b1;
          stall_cnt       <= stall_cnt + 1;
        end else begin
          avm_waitrequest <= 1'b0;
          stall_cnt       <= 0;
          if (avm_write) begin
            if (wr_q.size() == 0) begin
              check("unexpected_write", 64'd1, 64'd0);
            end else begin
              exp_wr = wr_q.pop_front();
              check("wr_addr", {61'd0, avm_address}, {61'd0, exp_wr[34:32]});
              check("wr_data", {32'd0, avm_writedata}, {32'd0, exp_wr[31:0]});
            end
          end else begin
            check("rd_addr", {61'd0, avm_address}, 64'd4);
            rd_acc_cyc <= cyc + 1;
            if (!cfg_norsp) rd_cnt <= cfg_lat;
            if (cfg_spur) begin
              avm_readdatavalid <= 1'b1;
              avm_readdata      <= 32'hBAD0_BAD0;
            end
          end
        end
      end else begin
        avm_waitrequest <= 1'b0;
        stall_cnt       <= 0;
      end
    end
  end

  task automatic push_exp(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic tmo);
    wr_q.push_back({3'd0, a});
    wr_q.push_back({3'd1, b});
    wr_q.push_back({3'd3, 32'h0000_0001});
    rsp_q.push_back({tmo, tmo ? 32'd0 : res});
  endtask

  task automatic send_cmd(input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic tmo);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_before_cmd", {63'd0, cmd_ready}, 64'd1);
    push_exp(a, b, res, tmo);
    cmd_a     = a;
    cmd_b     = b;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  // Latency counts the handshake edge as cycle 1
  task automatic wait_rsp(input int exp_lat);
    int n = 0;
    logic [32:0] e;
    while (!rsp_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("rsp_valid_seen", {63'd0, rsp_valid}, 64'd1);
    check("rsp_latency", 64'(cyc - hs_cyc + 1), 64'(exp_lat));
    if (rsp_q.size() == 0) begin
      check("unexpected_rsp", 64'd1, 64'd0);
    end else begin
      e = rsp_q.pop_front();
      check("rsp_result", {32'd0, rsp_result}, {32'd0, e[31:0]});
      check("rsp_timeout", {63'd0, rsp_timeout}, {63'd0, e[32]});
    end
  endtask

  task automatic ack_rsp(input int delay, input int exp_ops);
    logic [32:0] held;
    held = {rsp_timeout, rsp_result};
    for (int i = 0; i < delay; i++) begin
      @(posedge clk);
      #1;
      check("rsp_held_valid", {63'd0, rsp_valid}, 64'd1);
      check("rsp_held_data", {31'd0, rsp_timeout, rsp_result}, {31'd0, held});
      check("cmd_ready_in_resp", {63'd0, cmd_ready}, 64'd0);
    end
    @(negedge clk);
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    check("ops_done", {48'd0, ops_done}, 64'(exp_ops));
    check("idle_after_rsp", {61'd0, rsp_valid, busy, cmd_ready}, 64'b001);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ctrl"}, {58'd0, cmd_ready, rsp_valid, rsp_timeout, avm_read, avm_write, busy}, 64'd0);
    check({tag, "_result"}, {32'd0, rsp_result}, 64'd0);
    check({tag, "_wdata"}, {32'd0, avm_writedata}, 64'd0);
    check({tag, "_addr_ops"}, {45'd0, avm_address, ops_done}, 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset state
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_state");
    @(negedge clk) reset = 1'b0;

    // 1: basic add 1.0 + 2.0
    cfg_rdata = 32'h4040_0000;
    send_cmd(32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 1'b0);
    wait_rsp(6);
    ack_rsp(0, 1);

    // 2: three stall cycles on every transfer, 1.5 + 2.5
    cfg_stall = 3;
    cfg_rdata = 32'h4080_0000;
    send_cmd(32'h3FC0_0000, 32'h4020_0000, 32'h4080_0000, 1'b0);
    wait_rsp(18);
    ack_rsp(0, 2);
    cfg_stall = 0;

    // 3: 20-cycle read latency plus a strobe in the acceptance cycle, 0.5 + 0.25
    use_long  = 1'b1;
    cfg_lat   = 20;
    cfg_spur  = 1'b1;
    cfg_rdata = 32'h3F40_0000;
    send_cmd(32'h3F00_0000, 32'h3E80_0000, 32'h3F40_0000, 1'b0);
    wait_rsp(25);
    ack_rsp(0, 1);
    cfg_spur  = 1'b0;
    cfg_lat   = 1;
    use_long  = 1'b0;

    // 4: slave never answers the read
    cfg_norsp = 1'b1;
    send_cmd(32'h4000_0000, 32'h4000_0000, 32'h0, 1'b1);
    wait_rsp(21);
    check("timeout_after_accept", 64'(cyc - rd_acc_cyc), 64'd16);
    ack_rsp(0, 3);
    cfg_norsp = 1'b0;

    // 5: response backpressure with the next command already waiting
    cfg_rdata = 32'h4080_0000;
    send_cmd(32'h4040_0000, 32'h3F80_0000, 32'h4080_0000, 1'b0);
    wait_rsp(6);
    @(negedge clk);
    cfg_rdata = 32'h3F80_0000;
    push_exp(32'hBF80_0000, 32'h4000_0000, 32'h3F80_0000, 1'b0);
    cmd_a     = 32'hBF80_0000;
    cmd_b     = 32'h4000_0000;
    cmd_valid = 1'b1;
    ack_rsp(10, 4);
    @(posedge clk);
    #1;
    check("next_cmd_accepted", {62'd0, busy, cmd_ready}, 64'b10);
    check("next_cmd_hs_edge", 64'(hs_cyc), 64'(cyc));
    cmd_valid = 1'b0;
    wait_rsp(6);
    ack_rsp(0, 5);

    // 6: reset while WR_B is stalled
    cfg_stall = 3;
    send_cmd(32'h4120_0000, 32'h4130_0000, 32'h41A8_0000, 1'b0);
    n = 0;
    while (!(avm_write && avm_address == 3'd1) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_wr_b", {62'd0, avm_write, avm_address == 3'd1}, 64'b11);
    @(negedge clk);
    #2 reset = 1'b1;
    #1 check_all_zero("mid_op_reset");
    check("long_ops_cleared", {48'd0, l_ops_done}, 64'd0);
    wr_q.delete();
    rsp_q.delete();
    cfg_stall = 0;
    repeat (2) @(posedge clk);
    #1 check_all_zero("reset_held");
    @(negedge clk) reset = 1'b0;
    cfg_rdata = 32'h4000_0000;
    send_cmd(32'h3F80_0000, 32'h3F80_0000, 32'h4000_0000, 1'b0);
    wait_rsp(6);
    ack_rsp(0, 1);

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
